// File: rtl/bus_to_alu_shifter8.sv
// Return-path shifter: takes a byte from the bus and applies the op one bit per clock.
// It then holds the result for the ALU under valid/ready. The latency is N+1 edges from accept, and load_ready stays low until the ALU consumes the result.
module bus_to_alu_shifter8 #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] from_bus,
    input  logic [1:0]       shift_operation,
    input  logic [CNT_W-1:0] shift_count,
    input  logic             load,
    output logic             load_ready,
    output logic [WIDTH-1:0] to_alu,
    output logic             alu_valid,
    input  logic             alu_ready
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    localparam logic [1:0]       OP_PASS = 2'b00;
    localparam logic [1:0]       OP_SRL  = 2'b01;
    localparam logic [1:0]       OP_SLL  = 2'b10;
    localparam logic [1:0]       OP_ROR  = 2'b11;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q,  data_d;
    logic [1:0]       op_q,    op_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            op_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (load) begin
                    data_d = from_bus;
                    op_d   = shift_operation;
                    cnt_d  = shift_count;
                    if (shift_operation == OP_PASS || shift_count == '0)
                        state_d = ST_HOLD;
                    else
                        state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                case (op_q)
                    OP_SRL:  data_d = {1'b0, data_q[WIDTH-1:1]};
                    OP_SLL:  data_d = {data_q[WIDTH-2:0], 1'b0};
                    OP_ROR:  data_d = {data_q[0], data_q[WIDTH-1:1]};
                    default: data_d = data_q;
                endcase
                cnt_d = cnt_q - CNT_ONE;
                // Final step lands on the same edge that leaves SHIFT, so cnt never wraps.
                if (cnt_q == CNT_ONE)
                    state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (alu_ready)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        load_ready = (state_q == ST_IDLE);
        alu_valid  = (state_q == ST_HOLD);
    end

    assign to_alu = data_q;

`ifdef DEBUG_bus_to_alu_shifter8
    always @(posedge clk) begin
        $display("%m state=%0d data=%h cnt=%0d", state_q, data_q, cnt_q);
    end
`endif

endmodule

// File: tb/tb_bus_to_alu_shifter8.sv
// Randomised and directed bench for bus_to_alu_shifter8 against an arithmetic reference model.
module tb_bus_to_alu_shifter8;

    logic       clk;
    logic       reset_n;
    logic [7:0] from_bus;
    logic [1:0] shift_operation;
    logic [2:0] shift_count;
    logic       load;
    logic       load_ready;
    logic [7:0] to_alu;
    logic       alu_valid;
    logic       alu_ready;

    int n_checks = 0;
    int n_errors = 0;

    bus_to_alu_shifter8 #(.WIDTH(8), .CNT_W(3)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .from_bus        (from_bus),
        .shift_operation (shift_operation),
        .shift_count     (shift_count),
        .load            (load),
        .load_ready      (load_ready),
        .to_alu          (to_alu),
        .alu_valid       (alu_valid),
        .alu_ready       (alu_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: whole-shift arithmetic, independent of the per-step datapath.
    function automatic logic [7:0] model_res(input logic [7:0] d, input logic [1:0] op, input int n);
        logic [15:0] w;
        if (op == 2'b00 || n == 0) return d;
        case (op)
            2'b01:   w = {8'h00, d} >> n;
            2'b10:   w = {8'h00, d} << n;
            default: w = {d, d} >> n;
        endcase
        return w[7:0];
    endfunction

    // Posedges from the accept edge (inclusive) until alu_valid is seen.
    function automatic int model_edges(input logic [1:0] op, input int n);
        return (op == 2'b00 || n == 0) ? 1 : n + 1;
    endfunction

    // Starts at a negedge in IDLE; returns at the negedge where alu_valid is first seen (or timeout).
    // Inputs and alu_ready are scrambled after acceptance to show they are ignored.
    task automatic issue(input logic [7:0] d, input logic [1:0] op, input logic [2:0] c,
                         output int edges, output logic [7:0] res);
        from_bus        = d;
        shift_operation = op;
        shift_count     = c;
        load            = 1'b1;
        alu_ready       = 1'($urandom_range(0, 1));
        @(posedge clk);
        @(negedge clk);
        edges = 1;
        while (alu_valid !== 1'b1 && edges < 40) begin
            load            = 1'($urandom_range(0, 1));
            from_bus        = 8'($urandom);
            shift_operation = 2'($urandom);
            shift_count     = 3'($urandom);
            alu_ready       = 1'($urandom_range(0, 1));
            @(posedge clk);
            @(negedge clk);
            edges++;
        end
        load      = 1'b0;
        alu_ready = 1'b0;
        res       = to_alu;
    endtask

    task automatic consume();
        alu_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        alu_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if (load_ready !== 1'b1 || alu_valid !== 1'b0 || to_alu !== 8'h00) begin
            n_errors++;
            $display("FAIL reset_vals: load_ready=%b alu_valid=%b to_alu=%h, want 1 0 00", load_ready, alu_valid, to_alu);
        end
        reset_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (load_ready !== 1'b1 || alu_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL post_reset_idle: load_ready=%b alu_valid=%b, want 1 0", load_ready, alu_valid);
        end
    endtask

    task automatic test_directed();
        logic [7:0] d[6]  = '{8'b1001_0110, 8'hF0, 8'h01, 8'h81, 8'hA5, 8'h3C};
        logic [1:0] op[6] = '{2'b11, 2'b01, 2'b10, 2'b11, 2'b00, 2'b01};
        logic [2:0] c[6]  = '{3'd1, 3'd3, 3'd7, 3'd7, 3'd5, 3'd0};
        logic [7:0] want[6] = '{8'b0100_1011, 8'h1E, 8'h80, 8'h03, 8'hA5, 8'h3C};
        int         want_e[6] = '{2, 4, 8, 8, 1, 1};
        int         edges;
        logic [7:0] res;
        for (int i = 0; i < 6; i++) begin
            issue(d[i], op[i], c[i], edges, res);
            n_checks++;
            if (edges != want_e[i]) begin
                n_errors++;
                $display("FAIL directed_lat[%0d]: edges=%0d want %0d", i, edges, want_e[i]);
            end
            n_checks++;
            if (res !== want[i]) begin
                n_errors++;
                $display("FAIL directed_data[%0d]: to_alu=%h want %h", i, res, want[i]);
            end
            consume();
        end
    endtask

    task automatic test_backpressure();
        int         edges;
        logic [7:0] want;
        want            = model_res(8'h5A, 2'b10, 4);
        from_bus        = 8'h5A;
        shift_operation = 2'b10;
        shift_count     = 3'd4;
        load            = 1'b1;
        @(posedge clk);
        @(negedge clk);
        from_bus        = 8'hFF;
        shift_operation = 2'b11;
        shift_count     = 3'd1;
        edges           = 1;
        while (alu_valid !== 1'b1 && edges < 40) begin
            @(posedge clk);
            @(negedge clk);
            edges++;
        end
        n_checks++;
        if (edges != model_edges(2'b10, 4) || to_alu !== want) begin
            n_errors++;
            $display("FAIL bp_result: edges=%0d to_alu=%h want %0d %h", edges, to_alu, model_edges(2'b10, 4), want);
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            n_checks++;
            if (alu_valid !== 1'b1 || load_ready !== 1'b0 || to_alu !== want) begin
                n_errors++;
                $display("FAIL bp_hold[%0d]: alu_valid=%b load_ready=%b to_alu=%h want 1 0 %h", i, alu_valid, load_ready, to_alu, want);
            end
        end
        load      = 1'b0;
        alu_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (load_ready !== 1'b1 || alu_valid !== 1'b0 || to_alu !== want) begin
            n_errors++;
            $display("FAIL bp_release: load_ready=%b alu_valid=%b to_alu=%h want 1 0 %h", load_ready, alu_valid, to_alu, want);
        end
        @(posedge clk);
        @(negedge clk);
        alu_ready = 1'b0;
        n_checks++;
        if (load_ready !== 1'b1 || alu_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL ready_in_idle: load_ready=%b alu_valid=%b want 1 0", load_ready, alu_valid);
        end
    endtask

    task automatic test_back_to_back();
        int         edges;
        logic [7:0] res, d;
        logic [1:0] op;
        logic [2:0] c;
        d  = 8'($urandom);
        op = 2'($urandom);
        c  = 3'($urandom);
        issue(d, op, c, edges, res);
        consume();
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (load_ready !== 1'b1 || alu_valid !== 1'b0) begin
                n_errors++;
                $display("FAIL b2b_gap[%0d]: load_ready=%b alu_valid=%b want 1 0", i, load_ready, alu_valid);
            end
            d  = 8'($urandom);
            op = 2'($urandom);
            c  = 3'($urandom);
            issue(d, op, c, edges, res);
            n_checks++;
            if (edges != model_edges(op, int'(c)) || res !== model_res(d, op, int'(c))) begin
                n_errors++;
                $display("FAIL b2b[%0d]: d=%h op=%0d c=%0d edges=%0d to_alu=%h want %0d %h", i, d, op, c,
                         edges, res, model_edges(op, int'(c)), model_res(d, op, int'(c)));
            end
            consume();
        end
    endtask

    task automatic test_random();
        int         edges, k;
        logic [7:0] res, d;
        logic [1:0] op;
        logic [2:0] c;
        for (int i = 0; i < 40; i++) begin
            d  = 8'($urandom);
            op = 2'($urandom);
            c  = 3'($urandom);
            issue(d, op, c, edges, res);
            n_checks++;
            if (edges != model_edges(op, int'(c)) || res !== model_res(d, op, int'(c))) begin
                n_errors++;
                $display("FAIL rand[%0d]: d=%h op=%0d c=%0d edges=%0d to_alu=%h want %0d %h", i, d, op, c,
                         edges, res, model_edges(op, int'(c)), model_res(d, op, int'(c)));
            end
            k = $urandom_range(0, 3);
            repeat (k) begin
                @(posedge clk);
                @(negedge clk);
            end
            n_checks++;
            if (alu_valid !== 1'b1 || to_alu !== model_res(d, op, int'(c))) begin
                n_errors++;
                $display("FAIL rand_hold[%0d]: alu_valid=%b to_alu=%h want 1 %h", i, alu_valid, to_alu, model_res(d, op, int'(c)));
            end
            consume();
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        int         edges;
        logic [7:0] res;
        from_bus        = 8'hC3;
        shift_operation = 2'b01;
        shift_count     = 3'd7;
        load            = 1'b1;
        @(posedge clk);
        @(negedge clk);
        load = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (load_ready !== 1'b0 || alu_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL in_shift: load_ready=%b alu_valid=%b want 0 0", load_ready, alu_valid);
        end
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if (load_ready !== 1'b1 || alu_valid !== 1'b0 || to_alu !== 8'h00) begin
            n_errors++;
            $display("FAIL reset_mid_shift: load_ready=%b alu_valid=%b to_alu=%h want 1 0 00", load_ready, alu_valid, to_alu);
        end
        @(negedge clk);
        reset_n = 1'b1;
        issue(8'h77, 2'b00, 3'd3, edges, res);
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if (load_ready !== 1'b1 || alu_valid !== 1'b0 || to_alu !== 8'h00) begin
            n_errors++;
            $display("FAIL reset_mid_hold: load_ready=%b alu_valid=%b to_alu=%h want 1 0 00", load_ready, alu_valid, to_alu);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        reset_n         = 1'b0;
        from_bus        = '0;
        shift_operation = '0;
        shift_count     = '0;
        load            = 1'b0;
        alu_ready       = 1'b0;
        test_reset();
        test_directed();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
